// File: rtl/ctrl_sequencer_pkg.sv
// Shared types and constants for the command sequencer and its FIFO.
package ctrl_sequencer_pkg;

    localparam int OP_W          = 7;
    localparam int LEN_W         = 3;
    localparam int STALL_W       = 8;
    localparam int STALL_MAX_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// Synchronous command FIFO; the head entry is read straight from flop storage.
module ctrl_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Command sequencer: queues control words and issues each for req_len+1 datapath beats.
//   state    | meaning
//   ST_IDLE  | waiting for a queued command
//   ST_ISSUE | driving dec_word, counting beats and stalls
//   ST_DONE  | one-cycle completion pulse, may pop the next command
//   ST_ERR   | one-cycle stall-timeout pulse, queue is discarded
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  flush,
    input  logic                  dp_stall,
    output logic [OP_W-1:0]       dec_word,
    output logic                  dec_valid,
    output logic                  done_valid,
    output logic [OP_W-1:0]       done_op,
    output logic                  err_timeout,
    output logic [$clog2(DEPTH):0] q_level
);

    localparam logic [STALL_W:0] STALL_LIM = STALL_MAX[STALL_W:0];

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [OP_W-1:0]     word_q, word_d;
    logic [OP_W-1:0]     done_op_q, done_op_d;
    logic                dec_valid_q, dec_valid_d;
    logic                done_valid_q, done_valid_d;
    logic                err_q, err_d;
    logic                ready_en_q;

    logic                fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [OP_W+LEN_W-1:0] fifo_head;
    logic [STALL_W:0]    stall_inc;

    assign req_ready  = ready_en_q && !fifo_full && !flush && (state_q != ST_ERR);
    assign fifo_push  = req_valid && req_ready;
    assign fifo_pop   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !fifo_empty && !flush;
    assign fifo_flush = flush || (state_q == ST_ERR);
    assign stall_inc  = {1'b0, stall_q} + 1'b1;

    ctrl_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W + LEN_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_len, req_op}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_d      = stall_q;
        word_d       = word_q;
        done_op_d    = done_op_q;
        dec_valid_d  = 1'b0;
        done_valid_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (fifo_pop) begin
                    state_d     = ST_ISSUE;
                    cnt_d       = fifo_head[OP_W +: LEN_W];
                    word_d      = fifo_head[OP_W-1:0];
                    stall_d     = '0;
                    dec_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (dp_stall) begin
                    stall_d = stall_inc[STALL_W-1:0];
                    if (stall_inc >= STALL_LIM) begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                        done_op_d = word_q;
                    end else begin
                        dec_valid_d = 1'b1;
                    end
                end else begin
                    stall_d = '0;
                    if (cnt_q == '0) begin
                        state_d      = ST_DONE;
                        done_valid_d = 1'b1;
                        done_op_d    = word_q;
                    end else begin
                        cnt_d       = cnt_q - 1'b1;
                        dec_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                stall_d = '0;
            end
        endcase
        // Flush wins over everything; a pulse already on the outputs is left to finish.
        if (flush) begin
            state_d      = ST_IDLE;
            stall_d      = '0;
            done_op_d    = done_op_q;
            dec_valid_d  = 1'b0;
            done_valid_d = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stall_q      <= '0;
            word_q       <= '0;
            done_op_q    <= '0;
            dec_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            err_q        <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stall_q      <= stall_d;
            word_q       <= word_d;
            done_op_q    <= done_op_d;
            dec_valid_q  <= dec_valid_d;
            done_valid_q <= done_valid_d;
            err_q        <= err_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign dec_word    = word_q;
    assign dec_valid   = dec_valid_q;
    assign done_valid  = done_valid_q;
    assign done_op     = done_op_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized and directed bench for ctrl_sequencer against a queue-based reference model.
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int SMAX  = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [OP_W-1:0]  req_op = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             flush = 1'b0;
    logic             dp_stall = 1'b0;
    logic [OP_W-1:0]  dec_word;
    logic             dec_valid;
    logic             done_valid;
    logic [OP_W-1:0]  done_op;
    logic             err_timeout;
    logic [$clog2(DEPTH):0] q_level;

    always #5 clk = ~clk;

    ctrl_sequencer #(.DEPTH(DEPTH), .STALL_MAX(SMAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_len     (req_len),
        .flush       (flush),
        .dp_stall    (dp_stall),
        .dec_word    (dec_word),
        .dec_valid   (dec_valid),
        .done_valid  (done_valid),
        .done_op     (done_op),
        .err_timeout (err_timeout),
        .q_level     (q_level)
    );

    // Reference model: pending commands, the active command's remaining beats, pulses.
    typedef struct {
        logic [6:0] op;
        logic [2:0] len;
    } cmd_t;

    cmd_t       mq[$];
    bit         m_ready_ok, m_busy, m_done, m_err;
    int         m_left, m_stalls;
    logic [6:0] m_word, m_done_op;
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready_ok = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_left = 0; m_stalls = 0; m_word = '0; m_done_op = '0;
    endtask

    task automatic check_outputs(input bit fl);
        bit exp_ready;
        exp_ready = m_ready_ok && (mq.size() < DEPTH) && !fl && !m_err;
        chk("req_ready",   32'(req_ready),   32'(exp_ready));
        chk("q_level",     32'(q_level),     32'(mq.size()));
        chk("dec_valid",   32'(dec_valid),   32'(m_busy));
        chk("dec_word",    32'(dec_word),    32'(m_word));
        chk("done_valid",  32'(done_valid),  32'(m_done));
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        chk("done_op",     32'(done_op),     32'(m_done_op));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit v, input logic [6:0] op, input logic [2:0] len,
                        input bit fl, input bit st);
        bit   acc;
        cmd_t c, h;
        req_valid = v; req_op = op; req_len = len; flush = fl; dp_stall = st;
        #1;
        check_outputs(fl);
        acc = v && m_ready_ok && (mq.size() < DEPTH) && !fl && !m_err;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_busy = 0; m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (m_err) begin
                mq.delete();
                m_err = 0;
            end else if (m_busy) begin
                if (st) begin
                    m_stalls++;
                    if (m_stalls >= SMAX) begin
                        m_busy = 0; m_err = 1; m_done_op = m_word;
                    end
                end else begin
                    m_stalls = 0;
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0; m_done = 1; m_done_op = m_word;
                    end
                end
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                m_busy = 1; m_left = int'(h.len) + 1; m_stalls = 0; m_word = h.op;
            end
            if (acc) begin
                c.op = op; c.len = len;
                mq.push_back(c);
            end
        end
        m_ready_ok = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 0; flush = 0; dp_stall = 0; req_op = '0; req_len = '0;
        #1;
        model_reset();
        check_outputs(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single op, len=2
        step(1, 7'h2A, 3'd2, 0, 0);
        idle(7);

        // Fill the queue while the first command stalls
        for (int i = 0; i < 6; i++) step(1, 7'(i + 1), 3'd7, 0, 1);
        idle(40);

        // Back-to-back len=0 commands
        step(1, 7'h11, 3'd0, 0, 0);
        step(1, 7'h22, 3'd0, 0, 0);
        idle(8);

        // Stall three cycles mid-issue
        step(1, 7'h05, 3'd1, 0, 0);
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 1);
        idle(6);

        // Timeout with pushes arriving during the stall
        step(1, 7'h33, 3'd3, 0, 0);
        for (int i = 0; i < 22; i++) step(1, 7'(8'h40 + i), 3'd1, 0, 1);
        idle(6);

        // Flush during issue with two queued
        for (int i = 0; i < 3; i++) step(1, 7'(8'h50 + i), 3'd4, 0, 0);
        step(0, '0, '0, 0, 0);
        step(1, 7'h7F, 3'd0, 1, 0);
        idle(6);

        // Reset mid-issue
        step(1, 7'h66, 3'd7, 0, 0);
        step(1, 7'h67, 3'd2, 0, 0);
        step(0, '0, '0, 0, 0);
        do_reset();
        idle(4);

        // Random traffic: light stalls, then stall-heavy
        for (int i = 0; i < 3000; i++) begin
            bit st;
            if (i < 1800) st = ($urandom_range(0, 4) == 0);
            else          st = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            step(bit'($urandom_range(0, 1)), 7'($urandom), 3'($urandom),
                 ($urandom_range(0, 59) == 0), st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set command FIFO entries (power of two, 2..16).
REQ-002 Parameter STALL_MAX, default 15, SHALL set the maximum consecutive stall cycles before a timeout (1..255).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  command offered.
REQ-006 req_ready  output  1  command can be accepted.
REQ-007 req_op  input  7  control word; bit i drives decoder input xi.
REQ-008 req_len  input  3  issue length minus one (1..8 cycles).
REQ-009 flush  input  1  synchronous abort of the queue and the active command.
REQ-010 dp_stall  input  1  datapath cannot consume the current word.
REQ-011 dec_word  output  7  control word to the ctrl decoder (x0..x6).
REQ-012 dec_valid  output  1  dec_word is live this cycle.
REQ-013 done_valid  output  1  one-cycle completion pulse.
REQ-014 done_op  output  7  op of the completed or aborted command, valid with done_valid or err_timeout.
REQ-015 err_timeout  output  1  one-cycle pulse on stall timeout.
REQ-016 q_level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 Handshake: a push SHALL occur when req_valid && req_ready; req_ready = !full && !flush && state!=ERR.
REQ-018 A push into a full FIFO SHALL be impossible; a pop and a push in the same cycle SHALL leave q_level unchanged.
REQ-019 States: IDLE, ISSUE, DONE, ERR.
REQ-020 IDLE: if the FIFO is non-empty, SHALL pop the head, load cnt=req_len and a 7-bit word register, and go to ISSUE next cycle.
REQ-021 A command pushed into an empty FIFO in IDLE at cycle T SHALL show dec_valid=1 at T+2.
REQ-022 ISSUE: dec_valid=1, dec_word=the latched op; if dp_stall=0, cnt decrements; the state exits to DONE when cnt==0 && dp_stall==0.
REQ-023 A command with no stalls SHALL hold dec_valid for exactly req_len+1 cycles.
REQ-024 Stall counter SHALL increment each ISSUE cycle with dp_stall=1, clear on dp_stall=0; reaching STALL_MAX SHALL go to ERR.
REQ-025 DONE: one cycle, done_valid=1, done_op=op, dec_valid=0; next state ISSUE (head popped, REQ-020 loading) if the FIFO is non-empty, else IDLE.
REQ-026 ERR: one cycle, err_timeout=1, done_op=op, FIFO emptied, then IDLE; no done_valid for the aborted op.
REQ-027 flush SHALL, in the same cycle, empty the FIFO, force the next state to IDLE, suppress done_valid, and drop any concurrent push; flush in ERR SHALL still give err_timeout.
REQ-028 dec_word SHALL hold its last value when dec_valid=0; consumers SHALL ignore it.
REQ-029 cnt 3-bit and stall counter 8-bit SHALL never wrap; FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, FIFO empty, q_level=0, cnt=0, stall counter=0, req_ready=0 while asserted, dec_valid=0, dec_word=0, done_valid=0, done_op=0, err_timeout=0.
REQ-031 Reset mid-ISSUE SHALL discard the active command with no done or err pulse; req_ready SHALL rise on the first clock after deassertion.

Structure
REQ-032 The shared package SHALL hold the state enum, OP_W=7, LEN_W=3 and the default STALL_MAX.
REQ-033 The FIFO SHALL be one sub-module, ctrl_cmd_fifo (sync, first-word registered, flush input); FSM and counters stay in the top.

Verification
REQ-034 Single op: push op=0x2A, len=2 into empty queue at T -> dec_valid T+2..T+4, dec_word=0x2A, done_valid at T+5, done_op=0x2A.
REQ-035 Fill: push 4 ops with no pop possible -> q_level=4, req_ready=0; the fifth offer is held until the first pop.
REQ-036 Back-to-back: two queued len=0 ops -> issue, DONE, issue, DONE; exactly one bubble cycle between dec_valid pulses.
REQ-037 Stall: len=1, dp_stall=1 for 3 cycles mid-issue -> dec_valid lasts 5 cycles, single done_valid.
REQ-038 Timeout: STALL_MAX=15, dp_stall held -> err_timeout at the 15th stall cycle +1, FIFO emptied, no done_valid.
REQ-039 Flush/reset: flush during ISSUE with 2 queued -> IDLE next cycle, q_level=0, no done; repeat with rst_n pulse -> all outputs at reset values.
